// File: rtl/inst_fifo_pkg.sv
// Shared constants and types for the instruction FIFO between IF and ID.
// The CTRL stall bus width and the position of the ID stall bit live here.
package inst_fifo_pkg;

    localparam int STALLBUS_WD   = 6;
    localparam int ID_STALL_BIT  = 2;
    localparam int ENTRY_WD      = 64;
    localparam int DEFAULT_DEPTH = 8;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fifo_entry_t;

    // Even parity over a full entry, available to checkers and future ECC use.
    function automatic logic entry_parity(input fifo_entry_t entry);
        return ^{entry.pc, entry.inst};
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Storage array for the instruction FIFO: one synchronous write port and
// one asynchronous read port; contents are intentionally not reset.
module fifo_mem #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/inst_fifo.sv
// Show-ahead instruction FIFO between IF and ID with almost-full stall request,
// exception flush and a sticky overflow flag.
module inst_fifo
    import inst_fifo_pkg::*;
#(
    parameter int DEPTH     = DEFAULT_DEPTH,
    parameter int AF_MARGIN = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [STALLBUS_WD-1:0]     stall,
    input  logic                       push_valid,
    input  logic [31:0]                push_pc,
    input  logic [31:0]                push_inst,
    output logic                       out_valid,
    output logic [31:0]                out_pc,
    output logic [31:0]                out_inst,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       stallreq_for_fifo,
    output logic                       overflow_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(DEPTH - AF_MARGIN);

    logic [AW-1:0] rptr_r, rptr_nxt;
    logic [AW-1:0] wptr_r, wptr_nxt;
    logic [CW-1:0] count_r, count_nxt;
    logic          ovf_r, ovf_nxt;

    logic          not_empty_s;
    logic          full_s;
    logic          pop_s;
    logic          push_s;
    logic          drop_s;
    fifo_entry_t   wdata_s;
    fifo_entry_t   rdata_s;
    logic          stall_unused_s;

    // Only the ID stall bit matters here; the rest of the bus is deliberately ignored.
    assign stall_unused_s = ^stall;

    assign not_empty_s = (count_r != {CW{1'b0}});
    assign full_s      = (count_r == FULL_CNT);
    assign pop_s       = not_empty_s && !stall[ID_STALL_BIT] && !flush;
    assign push_s      = push_valid && !flush && (!full_s || pop_s);
    assign drop_s      = push_valid && !flush && full_s && !pop_s;

    assign wdata_s.pc   = push_pc;
    assign wdata_s.inst = push_inst;

    fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_WD)
    ) u_mem (
        .clk   (clk),
        .we    (push_s),
        .waddr (wptr_r),
        .wdata (wdata_s),
        .raddr (rptr_r),
        .rdata (rdata_s)
    );

    // Next-state for pointers, occupancy and the sticky overflow flag; flush wins.
    always_comb begin
        rptr_nxt  = rptr_r;
        wptr_nxt  = wptr_r;
        count_nxt = count_r;
        ovf_nxt   = ovf_r;
        if (flush) begin
            rptr_nxt  = {AW{1'b0}};
            wptr_nxt  = {AW{1'b0}};
            count_nxt = {CW{1'b0}};
        end else begin
            if (pop_s) begin
                rptr_nxt = rptr_r + AW'(1'b1);
            end else begin
                rptr_nxt = rptr_r;
            end
            if (push_s) begin
                wptr_nxt = wptr_r + AW'(1'b1);
            end else begin
                wptr_nxt = wptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_nxt = count_r + CW'(1'b1);
                2'b01:   count_nxt = count_r - CW'(1'b1);
                default: count_nxt = count_r;
            endcase
            if (drop_s) begin
                ovf_nxt = 1'b1;
            end else begin
                ovf_nxt = ovf_r;
            end
        end
    end

    // Control state registers, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rptr_r  <= {AW{1'b0}};
            wptr_r  <= {AW{1'b0}};
            count_r <= {CW{1'b0}};
            ovf_r   <= 1'b0;
        end else begin
            rptr_r  <= rptr_nxt;
            wptr_r  <= wptr_nxt;
            count_r <= count_nxt;
            ovf_r   <= ovf_nxt;
        end
    end

    // Show-ahead head entry, forced to zero when empty so stale storage never leaks.
    always_comb begin
        if (not_empty_s) begin
            out_pc   = rdata_s.pc;
            out_inst = rdata_s.inst;
        end else begin
            out_pc   = 32'h0000_0000;
            out_inst = 32'h0000_0000;
        end
    end

    assign out_valid         = not_empty_s;
    assign count             = count_r;
    assign stallreq_for_fifo = (count_r >= AF_CNT);
    assign overflow_err      = ovf_r;

endmodule
